// File: rtl/board_render_uart.sv
// board_render_uart
//   Latches a ROWS x COLS board (one occupancy vector per player) on a start
//   request and streams it as ASCII text, one byte per handshake, to a
//   uart_tx-style sink. Optional '|' / "-+-" grid, CR LF line endings, and a
//   conflict marker for cells claimed by more than one player.
// Ports
//   clk        system clock
//   reset_n    asynchronous reset, active low
//   wr         start request, accepted only while ready=1
//   board      player p cell (r,c) = board[p*ROWS*COLS + r*COLS + c]
//   ready      1 = idle, will accept wr
//   done       one-cycle pulse once the sink has taken the last byte
//   uart_wr    one-cycle byte strobe to the sink
//   uart_din   byte for the sink, held between strobes
//   uart_ready sink idle; drops after accepting a byte
module board_render_uart #(
    parameter int unsigned ROWS        = 3,
    parameter int unsigned COLS        = 3,
    parameter int unsigned PLAYERS     = 2,
    parameter int unsigned BORDER      = 1,
    parameter logic [31:0] SYMBOLS     = 32'h2A2B4F58,
    parameter logic [7:0]  EMPTY_CH    = 8'h2E,
    parameter logic [7:0]  CONFLICT_CH = 8'h23
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr,
    input  logic [PLAYERS*ROWS*COLS-1:0]  board,
    output logic                          ready,
    output logic                          done,
    output logic                          uart_wr,
    output logic [7:0]                    uart_din,
    input  logic                          uart_ready
);

    localparam int unsigned CELLS    = ROWS * COLS;
    localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
    localparam logic [4:0]  COL_LAST = 5'(COLS - 1);
    localparam logic [4:0]  SEP_LAST = 5'(2 * COLS - 2);

    typedef enum logic [2:0] {StIdle, StEmit, StWaitBusy, StWaitIdle, StFin} state_t;
    typedef enum logic [2:0] {FCell, FVbar, FSep, FCr, FLf} field_t;

    state_t                      state_q;
    field_t                      field_q, field_d;
    logic [3:0]                  row_q, row_d;
    // Cell column on text rows, character position on separator rows.
    logic [4:0]                  col_q, col_d;
    logic                        sep_q, sep_d;    // current line is a separator line
    logic                        last_q, last_d;  // byte just sent ends the frame
    logic [PLAYERS*ROWS*COLS-1:0] snap_q;

    logic [7:0]       byte_d;
    logic [7:0]       cell_ch;
    logic [2:0]       hits;
    int unsigned      who;
    int unsigned      cell_idx;
    logic [CELLS-1:0] plane;
    logic [CELLS-1:0] plane_sh;
    logic [31:0]      sym_sh;

    // Character for the current cell: count players claiming it.
    always_comb begin
        hits     = '0;
        who      = 0;
        plane    = '0;
        plane_sh = '0;
        cell_idx = 32'(row_q) * COLS + 32'(col_q);
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            plane    = snap_q[p*CELLS +: CELLS];
            plane_sh = plane >> cell_idx;
            if (plane_sh[0]) begin
                hits = hits + 3'd1;
                who  = p;
            end
        end
        sym_sh = SYMBOLS >> (8 * who);
        if (hits == 3'd0) begin
            cell_ch = EMPTY_CH;
        end else if (hits == 3'd1) begin
            cell_ch = sym_sh[7:0];
        end else begin
            cell_ch = CONFLICT_CH;
        end
    end

    // Byte for the current position and the position that follows it.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        field_d = field_q;
        sep_d   = sep_q;
        last_d  = 1'b0;
        byte_d  = 8'h00;
        unique case (field_q)
            FCell: begin
                byte_d = cell_ch;
                if (col_q == COL_LAST) begin
                    field_d = FCr;
                end else if (BORDER != 0) begin
                    field_d = FVbar;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            FVbar: begin
                byte_d  = 8'h7C;
                col_d   = col_q + 5'd1;
                field_d = FCell;
            end
            FSep: begin
                byte_d = col_q[0] ? 8'h2B : 8'h2D;
                if (col_q == SEP_LAST) begin
                    field_d = FCr;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            FCr: begin
                byte_d  = 8'h0D;
                field_d = FLf;
            end
            FLf: begin
                byte_d = 8'h0A;
                col_d  = '0;
                if (sep_q) begin
                    row_d   = row_q + 4'd1;
                    field_d = FCell;
                    sep_d   = 1'b0;
                end else if (row_q == ROW_LAST) begin
                    last_d = 1'b1;
                end else if (BORDER != 0) begin
                    field_d = FSep;
                    sep_d   = 1'b1;
                end else begin
                    row_d   = row_q + 4'd1;
                    field_d = FCell;
                end
            end
            default: field_d = FCell;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ready    <= 1'b1;
            done     <= 1'b0;
            uart_wr  <= 1'b0;
            uart_din <= 8'h00;
            row_q    <= '0;
            col_q    <= '0;
            field_q  <= FCell;
            sep_q    <= 1'b0;
            last_q   <= 1'b0;
            snap_q   <= '0;
        end else begin
            uart_wr <= 1'b0;
            done    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wr) begin
                        snap_q  <= board;
                        ready   <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        field_q <= FCell;
                        sep_q   <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    if (uart_ready) begin
                        uart_wr  <= 1'b1;
                        uart_din <= byte_d;
                        row_q    <= row_d;
                        col_q    <= col_d;
                        field_q  <= field_d;
                        sep_q    <= sep_d;
                        last_q   <= last_d;
                        state_q  <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (!uart_ready) state_q <= StWaitIdle;
                end
                StWaitIdle: begin
                    if (uart_ready) begin
                        if (last_q) begin
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            state_q <= StEmit;
                        end
                    end
                end
                StFin: begin
                    ready   <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_board_render_uart.sv
// Bench for board_render_uart: three instances (default grid, no border,
// four players), each driving a sink model with configurable busy time.
module tb_board_render_uart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [2:0]  wrv = 3'b000;
    logic [17:0] b0 = '0;
    logic [17:0] b1 = '0;
    logic [35:0] b2 = '0;
    logic [2:0]  rdy_o, done_o, uwr;
    logic [7:0]  din [3];
    logic [2:0]  s_rdy = 3'b111;

    board_render_uart dut0 (
        .clk(clk), .reset_n(reset_n), .wr(wrv[0]), .board(b0), .ready(rdy_o[0]),
        .done(done_o[0]), .uart_wr(uwr[0]), .uart_din(din[0]), .uart_ready(s_rdy[0])
    );

    board_render_uart #(.BORDER(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .wr(wrv[1]), .board(b1), .ready(rdy_o[1]),
        .done(done_o[1]), .uart_wr(uwr[1]), .uart_din(din[1]), .uart_ready(s_rdy[1])
    );

    board_render_uart #(.PLAYERS(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .wr(wrv[2]), .board(b2), .ready(rdy_o[2]),
        .done(done_o[2]), .uart_wr(uwr[2]), .uart_din(din[2]), .uart_ready(s_rdy[2])
    );

    // Sink model: takes a byte on a strobe, stays busy delay[k]+1 cycles.
    int         delay [3] = '{0, 0, 0};
    int         cnt   [3] = '{0, 0, 0};
    int         ncap  [3] = '{0, 0, 0};
    int         ndone [3] = '{0, 0, 0};
    logic [7:0] cap   [3][512];
    int         viol = 0;
    logic [2:0] prev_wr = 3'b000;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (uwr[k]) begin
                if (!s_rdy[k] || prev_wr[k]) viol = viol + 1;
                if (ncap[k] < 512) cap[k][ncap[k]] = din[k];
                ncap[k]  = ncap[k] + 1;
                s_rdy[k] = 1'b0;
                cnt[k]   = delay[k];
            end else if (!s_rdy[k]) begin
                if (cnt[k] == 0) s_rdy[k] = 1'b1;
                else cnt[k] = cnt[k] - 1;
            end
            if (done_o[k]) ndone[k] = ndone[k] + 1;
            prev_wr[k] = uwr[k];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // '~' in an expected string stands for CR LF.
    logic [7:0] exp_q [$];

    task automatic fill_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h7E) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(s[i]);
            end
        end
    endtask

    task automatic start_frame(input int k, input logic [35:0] brd, input string name,
                               output int base, output int d0);
        @(negedge clk);
        #1;
        check({name, " ready before start"}, int'(rdy_o[k]), 1);
        base = ncap[k];
        d0   = ndone[k];
        case (k)
            0: b0 = brd[17:0];
            1: b1 = brd[17:0];
            default: b2 = brd;
        endcase
        wrv[k] = 1'b1;
        @(negedge clk);
        wrv[k] = 1'b0;
    endtask

    task automatic finish_frame(input int k, input int base, input int d0, input string name,
                                input int budget);
        int waited  = 0;
        int rdy_bad = 0;
        int act;
        while (ndone[k] == d0 && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
            if (ndone[k] == d0 && rdy_o[k]) rdy_bad++;
        end
        check({name, " done seen"}, int'(ndone[k] > d0), 1);
        check({name, " ready low in frame"}, rdy_bad, 0);
        repeat (4) @(negedge clk);
        #1;
        check({name, " ready after done"}, int'(rdy_o[k]), 1);
        check({name, " done pulses"}, ndone[k] - d0, 1);
        check({name, " byte count"}, ncap[k] - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (base + i < ncap[k] && base + i < 512) ? int'(cap[k][base + i]) : -1;
            check($sformatf("%s byte %0d", name, i), act, int'(exp_q[i]));
        end
    endtask

    typedef struct {
        int          inst;
        logic [35:0] brd;
        int          dly;
        string       exp;
        string       name;
    } vec_t;

    localparam logic [8:0] P0 = 9'b100010001;
    localparam logic [8:0] P1 = 9'b010101010;
    localparam string T1_EXP = "X|O|.~-+-+-~O|X|O~-+-+-~.|O|X~";

    vec_t vecs [6];

    initial begin
        int base, d0, waited;

        vecs[0] = '{0, {18'd0, P1, P0}, 0, T1_EXP, "t1"};
        vecs[1] = '{0, {18'd0, P1, P0}, 3, T1_EXP, "t1_slow3"};
        vecs[2] = '{1, {18'd0, P1, P0}, 0, "XO.~OXO~.OX~", "t2_noborder"};
        vecs[3] = '{2, {9'h010, 9'h100, 9'h001, 9'h001}, 0,
                    "#|.|.~-+-+-~.|*|.~-+-+-~.|.|+~", "t3_players"};
        vecs[4] = '{2, {9'h000, 9'h000, 9'h1FF, 9'h100}, 2,
                    "O|O|O~-+-+-~O|O|O~-+-+-~O|O|#~", "t3_conflict_last"};
        vecs[5] = '{0, {18'd0, P1, P0}, 1000, T1_EXP, "t6_slow1000"};

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ready %0d", k), int'(rdy_o[k]), 1);
            check($sformatf("reset done %0d", k), int'(done_o[k]), 0);
            check($sformatf("reset uart_wr %0d", k), int'(uwr[k]), 0);
            check($sformatf("reset uart_din %0d", k), int'(din[k]), 0);
        end
        reset_n = 1'b1;

        foreach (vecs[v]) begin
            delay[vecs[v].inst] = vecs[v].dly;
            fill_exp(vecs[v].exp);
            start_frame(vecs[v].inst, vecs[v].brd, vecs[v].name, base, d0);
            finish_frame(vecs[v].inst, base, d0, vecs[v].name, (vecs[v].dly + 10) * 60);
        end
        delay[0] = 0;

        // Extra wr and board change mid-frame must not disturb the snapshot.
        fill_exp(T1_EXP);
        start_frame(0, {18'd0, P1, P0}, "t4", base, d0);
        repeat (12) @(negedge clk);
        b0     = 18'h3FFFF;
        wrv[0] = 1'b1;
        repeat (2) @(negedge clk);
        wrv[0] = 1'b0;
        finish_frame(0, base, d0, "t4", 600);
        repeat (40) @(negedge clk);
        #1;
        check("t4 no restart", ncap[0] - base, 35);

        // Reset during the tenth byte aborts; the next request starts over.
        start_frame(0, {18'd0, P1, P0}, "t5", base, d0);
        waited = 0;
        while (ncap[0] - base < 10 && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("t5 reached byte 10", ncap[0] - base, 10);
        reset_n = 1'b0;
        #1;
        check("t5 ready in reset", int'(rdy_o[0]), 1);
        check("t5 uart_wr in reset", int'(uwr[0]), 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5 prefix byte %0d", i), int'(cap[0][base + i]), int'(exp_q[i]));
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t5 no bytes after abort", ncap[0] - base, 10);
        check("t5 ready after abort", int'(rdy_o[0]), 1);
        start_frame(0, {18'd0, P1, P0}, "t5_restart", base, d0);
        finish_frame(0, base, d0, "t5_restart", 600);

        check("sink protocol violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
